// File: rtl/phase_driver_pkg.sv
// Shared types for the three-phase gate driver: per-phase FSM state and dead-time counter width.
package phase_driver_pkg;

    localparam int DEAD_CNT_W = 8;

    typedef enum logic [2:0] {
        OFF          = 3'd0,
        HIGH_ON      = 3'd1,
        DEAD_TO_HIGH = 3'd2,
        LOW_ON       = 3'd3,
        DEAD_TO_LOW  = 3'd4
    } phase_state_e;

    // True on the last cycle of a dead interval; a zero dead time still costs one cycle.
    function automatic logic dead_done(input logic [DEAD_CNT_W-1:0] cnt,
                                       input logic [DEAD_CNT_W-1:0] dead_time);
        return ({1'b0, cnt} + {{DEAD_CNT_W{1'b0}}, 1'b1}) >= {1'b0, dead_time};
    endfunction

endpackage

// File: rtl/dead_time_fsm.sv
// Single half-bridge phase: turns the raw comparator level into break-before-make gate drives.
module dead_time_fsm
    import phase_driver_pkg::*;
#(
    parameter int DEAD_TIME = 8
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw_high,
    input  logic force_off,
    output logic pwm_high,
    output logic pwm_low
);

    localparam logic [DEAD_CNT_W-1:0] DEAD_TIME_C = DEAD_CNT_W'(DEAD_TIME);
    localparam logic [DEAD_CNT_W-1:0] CNT_ONE     = DEAD_CNT_W'(1);

    phase_state_e          state_r;
    logic [DEAD_CNT_W-1:0] dead_cnt_r;
    logic                  pwm_high_r;
    logic                  pwm_low_r;

    // Phase state, dead counter and gate drives all advance on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= OFF;
            dead_cnt_r <= '0;
            pwm_high_r <= 1'b0;
            pwm_low_r  <= 1'b0;
        end else if (force_off) begin
            state_r    <= OFF;
            dead_cnt_r <= '0;
            pwm_high_r <= 1'b0;
            pwm_low_r  <= 1'b0;
        end else begin
            case (state_r)
                OFF: begin
                    state_r    <= raw_high ? DEAD_TO_HIGH : DEAD_TO_LOW;
                    dead_cnt_r <= '0;
                    pwm_high_r <= 1'b0;
                    pwm_low_r  <= 1'b0;
                end
                HIGH_ON: begin
                    if (!raw_high) begin
                        state_r    <= DEAD_TO_LOW;
                        dead_cnt_r <= '0;
                        pwm_high_r <= 1'b0;
                        pwm_low_r  <= 1'b0;
                    end else begin
                        pwm_high_r <= 1'b1;
                        pwm_low_r  <= 1'b0;
                    end
                end
                LOW_ON: begin
                    if (raw_high) begin
                        state_r    <= DEAD_TO_HIGH;
                        dead_cnt_r <= '0;
                        pwm_high_r <= 1'b0;
                        pwm_low_r  <= 1'b0;
                    end else begin
                        pwm_high_r <= 1'b0;
                        pwm_low_r  <= 1'b1;
                    end
                end
                DEAD_TO_HIGH, DEAD_TO_LOW: begin
                    // Target side is chosen from raw_high on the expiry cycle, not on entry
                    if (dead_done(dead_cnt_r, DEAD_TIME_C)) begin
                        state_r    <= raw_high ? HIGH_ON : LOW_ON;
                        dead_cnt_r <= '0;
                        pwm_high_r <= raw_high;
                        pwm_low_r  <= ~raw_high;
                    end else begin
                        dead_cnt_r <= dead_cnt_r + CNT_ONE;
                        pwm_high_r <= 1'b0;
                        pwm_low_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= OFF;
                    dead_cnt_r <= '0;
                    pwm_high_r <= 1'b0;
                    pwm_low_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_high = pwm_high_r;
    assign pwm_low  = pwm_low_r;

endmodule

// File: rtl/three_phase_driver.sv
// Center-aligned PWM driver with shadowed duty/float registers and per-phase dead-time FSMs.
// Optional fault input pair enabled by THREE_PHASE_DRIVER_FAULT_EN.
module three_phase_driver
    import phase_driver_pkg::*;
#(
    parameter int NUM_PHASES    = 3,
    parameter int COUNTER_WIDTH = 10,
    parameter int MAX_COUNTER   = 'h3ff,
    parameter int DEAD_TIME     = 8
)
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PHASES*COUNTER_WIDTH-1:0] duty_in,
    input  logic [NUM_PHASES-1:0]               high_z_in,
    input  logic                                duty_wr,
`ifdef THREE_PHASE_DRIVER_FAULT_EN
    input  logic                                fault_n,
    input  logic                                fault_clr,
`endif
    output logic [NUM_PHASES-1:0]               pwm_high,
    output logic [NUM_PHASES-1:0]               pwm_low,
    output logic                                update_pending,
    output logic                                period_start
);

    localparam int                     CW    = COUNTER_WIDTH;
    localparam logic [CW-1:0]          MAX_C = CW'(MAX_COUNTER);
    localparam logic [CW-1:0]          ONE_C = CW'(1);

    logic [CW-1:0]            counter_r;
    logic [CW-1:0]            counter_next_s;
    logic                     dir_up_r;
    logic                     dir_up_next_s;
    logic                     period_start_r;
    logic [NUM_PHASES*CW-1:0] shadow_duty_r;
    logic [NUM_PHASES*CW-1:0] active_duty_r;
    logic [NUM_PHASES-1:0]    shadow_hz_r;
    logic [NUM_PHASES-1:0]    active_hz_r;
    logic                     pending_r;
    logic                     fault_active_s;
    logic                     write_en_s;

`ifdef THREE_PHASE_DRIVER_FAULT_EN
    logic fault_latched_r;

    // Fault latch: set by fault_n low, cleared only by fault_clr once fault_n has returned high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_latched_r <= 1'b0;
        end else if (!fault_n) begin
            fault_latched_r <= 1'b1;
        end else if (fault_clr) begin
            fault_latched_r <= 1'b0;
        end else begin
            fault_latched_r <= fault_latched_r;
        end
    end

    assign fault_active_s = fault_latched_r | ~fault_n;
`else
    assign fault_active_s = 1'b0;
`endif

    assign write_en_s = duty_wr & ~fault_active_s;

    // Triangle carrier: turn around at both extremes without repeating the end value
    always_comb begin
        counter_next_s = counter_r;
        dir_up_next_s  = dir_up_r;
        if (dir_up_r) begin
            if (counter_r >= MAX_C) begin
                counter_next_s = counter_r - ONE_C;
                dir_up_next_s  = 1'b0;
            end else begin
                counter_next_s = counter_r + ONE_C;
            end
        end else begin
            if (counter_r == '0) begin
                counter_next_s = ONE_C;
                dir_up_next_s  = 1'b1;
            end else begin
                counter_next_s = counter_r - ONE_C;
            end
        end
    end

    // Carrier registers; period_start is precomputed so it lines up with counter_r == 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_r      <= '0;
            dir_up_r       <= 1'b1;
            period_start_r <= 1'b0;
        end else begin
            counter_r      <= counter_next_s;
            dir_up_r       <= dir_up_next_s;
            period_start_r <= (counter_next_s == '0);
        end
    end

    // Shadow/active double buffer; a write on the boundary cycle bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_duty_r <= '0;
            active_duty_r <= '0;
            shadow_hz_r   <= '1;
            active_hz_r   <= '1;
            pending_r     <= 1'b0;
        end else begin
            if (write_en_s) begin
                shadow_duty_r <= duty_in;
                shadow_hz_r   <= high_z_in;
            end
            if (period_start_r) begin
                active_duty_r <= write_en_s ? duty_in   : shadow_duty_r;
                active_hz_r   <= write_en_s ? high_z_in : shadow_hz_r;
                pending_r     <= 1'b0;
            end else if (write_en_s) begin
                pending_r     <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_phase
        logic [CW-1:0] duty_s;
        logic          raw_high_s;

        assign duty_s     = active_duty_r[i*CW +: CW];
        assign raw_high_s = (duty_s >= MAX_C) | (duty_s > counter_r);

        dead_time_fsm #(
            .DEAD_TIME (DEAD_TIME)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_high  (raw_high_s),
            .force_off (active_hz_r[i] | fault_active_s),
            .pwm_high  (pwm_high[i]),
            .pwm_low   (pwm_low[i])
        );
    end

    assign update_pending = pending_r;
    assign period_start   = period_start_r;

endmodule
